// File: rtl/wb_retire_unit_pkg.sv
// Shared types and constants for the writeback/retire stage:
// write-data source codes, funct3 encodings and the retired-entry layout.
package wb_pkg;

    localparam int unsigned WB_XLEN = 32;
    localparam int unsigned WB_RA_W = 5;

    typedef enum logic [1:0] {
        WD_ALU  = 2'b00,
        WD_IMMU = 2'b01,
        WD_LOAD = 2'b10,
        WD_PC4  = 2'b11
    } wd_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Retired entry at the default core configuration
    typedef struct packed {
        logic               reg_write;
        logic [WB_RA_W-1:0] rd;
        logic [WB_XLEN-1:0] result;
        logic [WB_XLEN-1:0] new_pc;
        logic               redirect;
    } wb_entry_t;

endpackage

// File: rtl/wb_retire_unit_if.sv
// Handshake and payload bundle between execute, the retire stage and its consumers.
interface wb_retire_unit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic            reg_write_i;
    logic [1:0]      wd_src_i;
    logic [RA_W-1:0] rd_i;
    logic [XLEN-1:0] imm_u_i;
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] load_data_i;
    logic [XLEN-1:0] pc_branch_i;
    logic [XLEN-1:0] pc_plus4_i;
    logic [2:0]      funct3_i;
    logic            branch_i;
    logic            jump_i;
    logic            alu_zero_i;
    logic            alu_lt_i;
    logic            alu_ltu_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic            reg_write_o;
    logic [RA_W-1:0] rd_o;
    logic [XLEN-1:0] result_o;
    logic [XLEN-1:0] new_pc_o;
    logic            redirect_o;
    logic [31:0]     retire_cnt_o;

    modport slave (
        input  in_valid_i, reg_write_i, wd_src_i, rd_i, imm_u_i, alu_result_i,
               load_data_i, pc_branch_i, pc_plus4_i, funct3_i, branch_i, jump_i,
               alu_zero_i, alu_lt_i, alu_ltu_i, out_ready_i,
        output in_ready_o, out_valid_o, reg_write_o, rd_o, result_o, new_pc_o,
               redirect_o, retire_cnt_o
    );

    modport master (
        output in_valid_i, reg_write_i, wd_src_i, rd_i, imm_u_i, alu_result_i,
               load_data_i, pc_branch_i, pc_plus4_i, funct3_i, branch_i, jump_i,
               alu_zero_i, alu_lt_i, alu_ltu_i, out_ready_i,
        input  in_ready_o, out_valid_o, reg_write_o, rd_o, result_o, new_pc_o,
               redirect_o, retire_cnt_o
    );
endinterface

// File: rtl/wb_retire_unit_queue.sv
// Count-based synchronous FIFO; a push is accepted while full if a pop happens in the same cycle.
module wb_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: selects write-back data, resolves branches/jumps
// and queues retired results in order for the register file and fetch.
module wb_retire_unit
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned DEPTH = 2
) (
    input logic              clk,
    input logic              rst_n,
    wb_retire_unit_if.slave  bus
);
    typedef struct packed {
        logic            reg_write;
        wd_src_e         wd_src;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm_u;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] load_data;
        logic [XLEN-1:0] pc_branch;
        logic [XLEN-1:0] pc_plus4;
        logic [2:0]      funct3;
        logic            branch;
        logic            jump;
        logic            alu_zero;
        logic            alu_lt;
        logic            alu_ltu;
    } stage_t;

    typedef struct packed {
        logic            reg_write;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] new_pc;
        logic            redirect;
    } q_entry_t;

    localparam int unsigned QW = $bits(q_entry_t);

    stage_t          stage_q, stage_d;
    logic            s_valid_q, s_valid_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;

    logic            push, pop, accept, in_ready;
    logic            q_empty, q_full;
    logic [QW-1:0]   q_rdata;
    q_entry_t        q_wdata, head;
    logic [XLEN-1:0] load_ext, result;
    logic            cond, taken;

    assign pop      = !q_empty && bus.out_ready_i;
    assign push     = s_valid_q && (!q_full || pop);
    assign in_ready = !s_valid_q || push;
    assign accept   = bus.in_valid_i && in_ready;

    // Load extension and write-back source select
    always_comb begin
        load_ext = XLEN'($signed(stage_q.load_data[31:0]));
        case (stage_q.funct3)
            F3_LB:   load_ext = XLEN'($signed(stage_q.load_data[7:0]));
            F3_LH:   load_ext = XLEN'($signed(stage_q.load_data[15:0]));
            F3_LW:   load_ext = XLEN'($signed(stage_q.load_data[31:0]));
            F3_LBU:  load_ext = XLEN'(stage_q.load_data[7:0]);
            F3_LHU:  load_ext = XLEN'(stage_q.load_data[15:0]);
            default: load_ext = XLEN'($signed(stage_q.load_data[31:0]));
        endcase
        result = stage_q.alu_result;
        case (stage_q.wd_src)
            WD_ALU:  result = stage_q.alu_result;
            WD_IMMU: result = stage_q.imm_u;
            WD_LOAD: result = load_ext;
            WD_PC4:  result = stage_q.pc_plus4;
            default: result = stage_q.alu_result;
        endcase
    end

    // Branch condition; funct3 010/011 never take
    always_comb begin
        cond = 1'b0;
        case (stage_q.funct3)
            F3_BEQ:  cond = stage_q.alu_zero;
            F3_BNE:  cond = !stage_q.alu_zero;
            F3_BLT:  cond = stage_q.alu_lt;
            F3_BGE:  cond = !stage_q.alu_lt;
            F3_BLTU: cond = stage_q.alu_ltu;
            F3_BGEU: cond = !stage_q.alu_ltu;
            default: cond = 1'b0;
        endcase
        taken = stage_q.jump || (stage_q.branch && cond);
    end

    always_comb begin
        q_wdata.reg_write = stage_q.reg_write && (stage_q.rd != '0);
        q_wdata.rd        = stage_q.rd;
        q_wdata.result    = result;
        q_wdata.new_pc    = taken ? stage_q.pc_branch : stage_q.pc_plus4;
        q_wdata.redirect  = taken;
    end

    always_comb begin
        s_valid_d    = s_valid_q;
        stage_d      = stage_q;
        retire_cnt_d = retire_cnt_q + 32'(pop);
        if (push) s_valid_d = 1'b0;
        if (accept) begin
            s_valid_d          = 1'b1;
            stage_d.reg_write  = bus.reg_write_i;
            stage_d.wd_src     = wd_src_e'(bus.wd_src_i);
            stage_d.rd         = bus.rd_i;
            stage_d.imm_u      = bus.imm_u_i;
            stage_d.alu_result = bus.alu_result_i;
            stage_d.load_data  = bus.load_data_i;
            stage_d.pc_branch  = bus.pc_branch_i;
            stage_d.pc_plus4   = bus.pc_plus4_i;
            stage_d.funct3     = bus.funct3_i;
            stage_d.branch     = bus.branch_i;
            stage_d.jump       = bus.jump_i;
            stage_d.alu_zero   = bus.alu_zero_i;
            stage_d.alu_lt     = bus.alu_lt_i;
            stage_d.alu_ltu    = bus.alu_ltu_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q    <= 1'b0;
            stage_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            s_valid_q    <= s_valid_d;
            stage_q      <= stage_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    wb_queue #(.DEPTH(DEPTH), .W(QW)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (q_wdata),
        .rdata_o (q_rdata),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    // Payload reads as zero whenever the queue is empty
    assign head = q_empty ? '0 : q_entry_t'(q_rdata);

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = !q_empty;
    assign bus.reg_write_o  = head.reg_write;
    assign bus.rd_o         = head.rd;
    assign bus.result_o     = head.result;
    assign bus.new_pc_o     = head.new_pc;
    assign bus.redirect_o   = head.redirect;
    assign bus.retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_wb_retire_unit.sv
// Scoreboard bench for wb_retire_unit: directed vectors push expected entries,
// a negedge monitor compares every popped head in order.
module tb_wb_retire_unit;
    import wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_retire_unit_if #(.XLEN(32), .RA_W(5)) bus ();

    wb_retire_unit #(.XLEN(32), .RA_W(5), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    wb_entry_t   sb[$];
    wb_entry_t   mon_e;
    logic [31:0] exp_retire;
    logic [31:0] base_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=rd%0d expected=none t=%0t", bus.rd_o, $time);
            end else begin
                mon_e = sb.pop_front();
                check("reg_write", 32'(bus.reg_write_o), 32'(mon_e.reg_write));
                check("rd",        32'(bus.rd_o),        32'(mon_e.rd));
                check("result",    bus.result_o,         mon_e.result);
                check("new_pc",    bus.new_pc_o,         mon_e.new_pc);
                check("redirect",  32'(bus.redirect_o),  32'(mon_e.redirect));
            end
            check("retire_cnt_at_pop", bus.retire_cnt_o, exp_retire);
            exp_retire = exp_retire + 32'd1;
        end
    end

    task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [2:0] f3, input logic br, input logic jp,
                         input logic z, input logic lt, input logic ltu,
                         input logic [31:0] immu, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pcb, input logic [31:0] pc4,
                         input logic erw, input logic [31:0] eres,
                         input logic [31:0] enpc, input logic ered);
        bus.reg_write_i  = rw;
        bus.wd_src_i     = src;
        bus.rd_i         = rd;
        bus.funct3_i     = f3;
        bus.branch_i     = br;
        bus.jump_i       = jp;
        bus.alu_zero_i   = z;
        bus.alu_lt_i     = lt;
        bus.alu_ltu_i    = ltu;
        bus.imm_u_i      = immu;
        bus.alu_result_i = alu;
        bus.load_data_i  = ld;
        bus.pc_branch_i  = pcb;
        bus.pc_plus4_i   = pc4;
        bus.in_valid_i   = 1'b1;
        sb.push_back('{reg_write: erw, rd: rd, result: eres, new_pc: enpc, redirect: ered});
    endtask

    task automatic wait_accept(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                @(posedge clk);
                #1;
                bus.in_valid_i = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=in_ready_low expected=accept t=%0t", $time);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.out_valid_o) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d_pending expected=0 t=%0t", sb.size(), $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i   = 1'b0;
        bus.reg_write_i  = 1'b0;
        bus.wd_src_i     = 2'b00;
        bus.rd_i         = '0;
        bus.funct3_i     = '0;
        bus.branch_i     = 1'b0;
        bus.jump_i       = 1'b0;
        bus.alu_zero_i   = 1'b0;
        bus.alu_lt_i     = 1'b0;
        bus.alu_ltu_i    = 1'b0;
        bus.imm_u_i      = '0;
        bus.alu_result_i = '0;
        bus.load_data_i  = '0;
        bus.pc_branch_i  = '0;
        bus.pc_plus4_i   = '0;
        bus.out_ready_i  = 1'b1;
        exp_retire       = '0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
        check("rst_retire",    bus.retire_cnt_o,     32'd0);
        check("rst_result",    bus.result_o,         32'd0);
        check("rst_new_pc",    bus.new_pc_o,         32'd0);
        check("rst_rd",        32'(bus.rd_o),        32'd0);
        check("rst_reg_write", 32'(bus.reg_write_o), 32'd0);
        check("rst_redirect",  32'(bus.redirect_o),  32'd0);

        // Two-cycle latency on a plain ALU op
        drive(1, 2'b00, 5'd5, 3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h1234, 32'h0, 32'h100, 32'h8,
              1, 32'h1234, 32'h8, 0);
        @(negedge clk);
        check("lat_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 32'(bus.out_valid_o), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(bus.out_valid_o), 32'd1);
        @(posedge clk);
        #1;

        // Loads of 0x000080F0 across all widths
        drive(1, 2'b10, 5'd6, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h0000_80F0, 32'h100, 32'h44, 1, 32'hFFFF_FFF0, 32'h44, 0); wait_accept(8);
        drive(1, 2'b10, 5'd6, 3'b100, 0, 0, 0, 0, 0, 0, 0, 32'h0000_80F0, 32'h100, 32'h44, 1, 32'h0000_00F0, 32'h44, 0); wait_accept(8);
        drive(1, 2'b10, 5'd6, 3'b001, 0, 0, 0, 0, 0, 0, 0, 32'h0000_80F0, 32'h100, 32'h44, 1, 32'hFFFF_80F0, 32'h44, 0); wait_accept(8);
        drive(1, 2'b10, 5'd6, 3'b101, 0, 0, 0, 0, 0, 0, 0, 32'h0000_80F0, 32'h100, 32'h44, 1, 32'h0000_80F0, 32'h44, 0); wait_accept(8);
        drive(1, 2'b10, 5'd6, 3'b010, 0, 0, 0, 0, 0, 0, 0, 32'h8000_80F0, 32'h100, 32'h44, 1, 32'h8000_80F0, 32'h44, 0); wait_accept(8);
        drive(1, 2'b10, 5'd6, 3'b011, 0, 0, 0, 0, 0, 0, 0, 32'h0000_80F0, 32'h100, 32'h44, 1, 32'h0000_80F0, 32'h44, 0); wait_accept(8);
        // U-immediate and JAL (pc+4 link, redirect)
        drive(1, 2'b01, 5'd7, 3'b000, 0, 0, 0, 0, 0, 32'hABCD_E000, 0, 0, 32'h100, 32'h44, 1, 32'hABCD_E000, 32'h44, 0); wait_accept(8);
        drive(1, 2'b11, 5'd1, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 32'h100, 32'h44, 1, 32'h44, 32'h100, 1); wait_accept(8);
        // Branch sweep
        drive(0, 2'b00, 5'd0, 3'b000, 1, 0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h100, 1); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b001, 1, 0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h44, 0); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b100, 1, 0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h100, 1); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b101, 1, 0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h44, 0); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b110, 1, 0, 0, 0, 1, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h100, 1); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b111, 1, 0, 0, 0, 1, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h44, 0); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b111, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h100, 1); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b010, 1, 0, 1, 1, 1, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h44, 0); wait_accept(8);
        drive(0, 2'b00, 5'd0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h44, 0, 32'h0, 32'h44, 0); wait_accept(8);
        // x0 destination never writes
        drive(1, 2'b00, 5'd0, 3'b000, 0, 0, 0, 0, 0, 0, 32'hDEAD, 0, 32'h100, 32'h44, 0, 32'hDEAD, 32'h44, 0); wait_accept(8);
        wait_drain(20);
        check("stream_retire", bus.retire_cnt_o, 32'd19);

        // Back-pressure: stage + two queue entries fill, fourth waits
        base_cnt = bus.retire_cnt_o;
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1, 2'b00, 5'(10 + k), 3'b000, 0, 0, 0, 0, 0, 0, 32'(32'hA0 + k), 0, 32'h100, 32'h44,
                  1, 32'(32'hA0 + k), 32'h44, 0);
            wait_accept(8);
        end
        drive(1, 2'b00, 5'd13, 3'b000, 0, 0, 0, 0, 0, 0, 32'hA3, 0, 32'h100, 32'h44, 1, 32'hA3, 32'h44, 0);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
        end
        check("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        wait_accept(8);
        wait_drain(20);
        check("bp_retire", bus.retire_cnt_o, base_cnt + 32'd4);

        // Counter wrap through 0xFFFFFFFF
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt_q;
        exp_retire = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            drive(1, 2'b00, 5'(20 + k), 3'b000, 0, 0, 0, 0, 0, 0, 32'(32'hC0 + k), 0, 32'h100, 32'h44,
                  1, 32'(32'hC0 + k), 32'h44, 0);
            wait_accept(8);
        end
        wait_drain(20);
        check("wrap_retire", bus.retire_cnt_o, 32'd1);

        // Asynchronous reset with entries queued
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1, 2'b00, 5'(25 + k), 3'b000, 0, 0, 0, 0, 0, 0, 32'h55, 0, 32'h100, 32'h44, 1, 32'h55, 32'h44, 0);
            wait_accept(8);
        end
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("mid_rst_retire",    bus.retire_cnt_o,     32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready_o),  32'd1);
        check("mid_rst_result",    bus.result_o,         32'd0);
        exp_retire = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        drive(1, 2'b01, 5'd31, 3'b000, 0, 0, 0, 0, 0, 32'h1234_5000, 0, 0, 32'h100, 32'h44, 1, 32'h1234_5000, 32'h44, 0);
        wait_accept(8);
        wait_drain(20);
        check("post_rst_retire", bus.retire_cnt_o, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
